// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one held multi-cycle access at a time, rdy pulse on completion.
// Define DMEM_ARB_RR_EN for round-robin arbitration on contention; the default build gives requester 0 fixed priority.
module dmem_arbiter #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        rdy0,
    output logic        rdy1,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       gnt_id;
    logic       lat_we;
    logic       win;

`ifdef DMEM_ARB_RR_EN
    logic       last_gnt;

    // On contention the requester not served last wins.
    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = ~last_gnt;
        else
            win = req1;
    end
`else
    always_comb begin
        win = ~req0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            gnt_id    <= 1'b0;
            lat_we    <= 1'b0;
            busy      <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata     <= 32'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
`ifdef DMEM_ARB_RR_EN
            last_gnt  <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id    <= win;
                        lat_we    <= win ? we1 : we0;
                        mem_addr  <= win ? addr1 : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        mem_read  <= ~(win ? we1 : we0);
                        mem_write <= win ? we1 : we0;
                        cnt       <= CNT_LOAD;
                        busy      <= 1'b1;
                        state     <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_gnt  <= win;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we)
                            rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rdy0      <= ~gnt_id;
                        rdy1      <= gnt_id;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    // Requests are ignored here so a held req is only re-granted from IDLE.
                    rdy0  <= 1'b0;
                    rdy1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
